// File: rtl/quad_rate_scheduler.sv
// Four-channel fractional rate scheduler: one shared adder/comparator walks the
// channels in turn on each tick. Optional sync_start port under QUAD_RATE_SCHED_SYNC_EN.
module quad_rate_scheduler #(
    parameter int COUNT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic [3:0]            enable,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_sel,
    input  logic [COUNT_BITS-1:0] cfg_multiplicand,
    input  logic [COUNT_BITS-1:0] cfg_dividend,
    input  logic                  overrun_clr,
`ifdef QUAD_RATE_SCHED_SYNC_EN
    input  logic                  sync_start,
`endif
    output logic [3:0]            step,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              slot_q, slot_d;
    logic [3:0]              step_q, step_d;
    logic                    overrun_q, overrun_d;
    logic [COUNT_BITS-1:0]   mult_q [4];
    logic [COUNT_BITS-1:0]   mult_d [4];
    logic [COUNT_BITS-1:0]   div_q  [4];
    logic [COUNT_BITS-1:0]   div_d  [4];
    logic [COUNT_BITS-1:0]   acc_q  [4];
    logic [COUNT_BITS-1:0]   acc_d  [4];

    logic [COUNT_BITS:0]     sum;
    logic [COUNT_BITS:0]     diff;
    logic [COUNT_BITS:0]     div_ext;
    logic                    active;
    logic                    set_ovr;

    assign div_ext = {1'b0, div_q[slot_q]};
    assign sum     = {1'b0, acc_q[slot_q]} + {1'b0, mult_q[slot_q]};
    assign diff    = sum - div_ext;

    // A config write to the channel being scanned takes priority over its update.
    assign active  = (state_q == SCAN) && enable[slot_q] && (div_q[slot_q] != '0)
                     && !(cfg_we && (cfg_sel == slot_q));

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        step_d    = '0;
        overrun_d = overrun_q;
        mult_d    = mult_q;
        div_d     = div_q;
        acc_d     = acc_q;
        set_ovr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    slot_d  = 2'd0;
                end
            end
            SCAN: begin
                if (tick) set_ovr = 1'b1;
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd3) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (active) begin
            if (sum >= div_ext) begin
                step_d[slot_q] = 1'b1;
                // Excess of more than one period is dropped so at most one step per tick.
                if (diff >= div_ext) begin
                    acc_d[slot_q] = div_q[slot_q] - 1'b1;
                    set_ovr       = 1'b1;
                end else begin
                    acc_d[slot_q] = diff[COUNT_BITS-1:0];
                end
            end else begin
                acc_d[slot_q] = sum[COUNT_BITS-1:0];
            end
        end

        if (cfg_we) begin
            mult_d[cfg_sel] = cfg_multiplicand;
            div_d[cfg_sel]  = cfg_dividend;
            acc_d[cfg_sel]  = '0;
        end

`ifdef QUAD_RATE_SCHED_SYNC_EN
        if (sync_start) begin
            for (int i = 0; i < 4; i++) acc_d[i] = '0;
            state_d = IDLE;
            slot_d  = 2'd0;
            step_d  = '0;
        end
`endif

        if (overrun_clr) overrun_d = 1'b0;
        if (set_ovr)     overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            slot_q    <= 2'd0;
            step_q    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mult_q[i] <= '0;
                div_q[i]  <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            step_q    <= step_d;
            overrun_q <= overrun_d;
            mult_q    <= mult_d;
            div_q     <= div_d;
            acc_q     <= acc_d;
        end
    end

    assign step    = step_q;
    assign busy    = (state_q == SCAN);
    assign overrun = overrun_q;

endmodule
